// File: rtl/flex_rx_deser_pkg.sv
// Shared types and width helpers for the flex_rx_deserializer receive stage.
// The PARITY state is only reachable when FLEX_RX_DESER_PARITY_EN is defined.
package flex_rx_deser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      PARITY = 2'd2
   } state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/flex_rx_deser_fifo.sv
// WIDTH x DEPTH holding FIFO. The head is read straight from the storage flops, so there is no bypass.
// A push is accepted when full only if a pop happens on the same edge.
module flex_rx_deser_fifo
   import flex_rx_deser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic [WIDTH-1:0]          head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok, push_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_ok) begin
         mem_d[wr_q] = push_data;
         wr_d        = ptr_inc(wr_q);
      end
      if (pop_ok) begin
         rd_d = ptr_inc(rd_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/flex_rx_deserializer.sv
// Serial-to-parallel USB receive stage: FSM, shift register, overrun status, holding FIFO.
// Define FLEX_RX_DESER_PARITY_EN to require a trailing odd-parity bit after every word.
module flex_rx_deserializer
   import flex_rx_deser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      shift_enable,
   input  logic                      serial_in,
   input  logic                      abort,
   input  logic                      clear_err,
   output logic [WIDTH-1:0]          rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
   output logic [cnt_w(DEPTH)-1:0]   fifo_count,
   output logic                      overrun
`ifdef FLEX_RX_DESER_PARITY_EN
   ,
   output logic                      parity_err
`endif
);

   localparam int BW = cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d, sr_shift, word_data;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             overrun_q, overrun_d;
   logic             word_done, last_bit, drop;
   logic             fifo_full, fifo_empty;
`ifdef FLEX_RX_DESER_PARITY_EN
   logic             parity_err_q, parity_err_d;
`endif

   if (MSB_FIRST != 0) begin : g_msb
      assign sr_shift = {sr_q[WIDTH-2:0], serial_in};
   end else begin : g_lsb
      assign sr_shift = {serial_in, sr_q[WIDTH-1:1]};
   end

   assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));
`ifdef FLEX_RX_DESER_PARITY_EN
   assign word_data = sr_q;
`else
   assign word_data = sr_shift;
`endif

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      word_done = 1'b0;
`ifdef FLEX_RX_DESER_PARITY_EN
      parity_err_d = 1'b0;
`endif
      // abort outranks any coincident bit, including the one that would complete a word
      if (abort) begin
         state_d   = IDLE;
         sr_d      = '0;
         bit_cnt_d = '0;
      end else if (shift_enable) begin
         case (state_q)
            IDLE, RECV: begin
               sr_d = sr_shift;
               if (last_bit) begin
`ifdef FLEX_RX_DESER_PARITY_EN
                  state_d   = PARITY;
                  bit_cnt_d = BW'(WIDTH);
`else
                  word_done = 1'b1;
                  state_d   = IDLE;
                  bit_cnt_d = '0;
                  sr_d      = '0;
`endif
               end else begin
                  state_d   = RECV;
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
            default: begin
`ifdef FLEX_RX_DESER_PARITY_EN
               word_done    = ^{sr_q, serial_in};
               parity_err_d = ~^{sr_q, serial_in};
`endif
               state_d   = IDLE;
               bit_cnt_d = '0;
               sr_d      = '0;
            end
         endcase
      end
   end

   assign drop      = word_done & fifo_full & ~(rx_valid & rx_ready);
   assign overrun_d = drop ? 1'b1 : (clear_err ? 1'b0 : overrun_q);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         overrun_q <= 1'b0;
`ifdef FLEX_RX_DESER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         overrun_q <= overrun_d;
`ifdef FLEX_RX_DESER_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   flex_rx_deser_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (word_done),
      .push_data (word_data),
      .pop       (rx_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (rx_data)
   );

   assign rx_valid = ~fifo_empty;
   assign bit_cnt  = bit_cnt_q;
   assign overrun  = overrun_q;
`ifdef FLEX_RX_DESER_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_flex_rx_deserializer.sv
// Directed bench for flex_rx_deserializer: one LSB-first and one MSB-first instance share stimulus.
module tb_flex_rx_deserializer;

   logic       clk = 1'b0;
   logic       n_rst, shift_enable, serial_in, abort, clear_err, rx_ready;
   logic [7:0] rx_data_l, rx_data_m;
   logic       rx_valid_l, rx_valid_m, overrun_l, overrun_m;
   logic [3:0] bit_cnt_l, bit_cnt_m;
   logic [1:0] fifo_count_l, fifo_count_m;
`ifdef FLEX_RX_DESER_PARITY_EN
   logic       parity_err_l, parity_err_m;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   flex_rx_deserializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
      .abort(abort), .clear_err(clear_err), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
      .rx_ready(rx_ready), .bit_cnt(bit_cnt_l), .fifo_count(fifo_count_l), .overrun(overrun_l)
`ifdef FLEX_RX_DESER_PARITY_EN
      , .parity_err(parity_err_l)
`endif
   );

   flex_rx_deserializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
      .abort(abort), .clear_err(clear_err), .rx_data(rx_data_m), .rx_valid(rx_valid_m),
      .rx_ready(rx_ready), .bit_cnt(bit_cnt_m), .fifo_count(fifo_count_m), .overrun(overrun_m)
`ifdef FLEX_RX_DESER_PARITY_EN
      , .parity_err(parity_err_m)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      shift_enable = 1'b1;
      serial_in    = b;
      tick();
      shift_enable = 1'b0;
      serial_in    = 1'b0;
   endtask

   // Bits go out w[0] first, so the LSB-first instance reassembles w unchanged.
   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(w[i]);
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0;
      abort = 1'b0; clear_err = 1'b0; rx_ready = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({rx_valid_l, rx_data_l, bit_cnt_l, fifo_count_l, overrun_l} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b data=%h cnt=%0d fc=%0d ovr=%b, need all 0",
                  rx_valid_l, rx_data_l, bit_cnt_l, fifo_count_l, overrun_l);
      end
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_bit_order();
      logic [7:0] bits;
      bits = 8'b0100_1101;
      for (int i = 0; i < 7; i++) send_bit(bits[i]);
      n_cmp++;
      if (bit_cnt_l !== 4'd7 || rx_valid_l !== 1'b0) begin
         n_err++;
         $display("FAIL order_partial: got cnt=%0d valid=%b, need cnt=7 valid=0", bit_cnt_l, rx_valid_l);
      end
      send_bit(bits[7]);
      n_cmp++;
      if (rx_valid_l !== 1'b1 || rx_data_l !== 8'h4D || bit_cnt_l !== 4'd0) begin
         n_err++;
         $display("FAIL lsb_first_word: got valid=%b data=%h cnt=%0d, need 1 4d 0", rx_valid_l, rx_data_l, bit_cnt_l);
      end
      n_cmp++;
      if (rx_valid_m !== 1'b1 || rx_data_m !== 8'hB2) begin
         n_err++;
         $display("FAIL msb_first_word: got valid=%b data=%h, need 1 b2", rx_valid_m, rx_data_m);
      end
      pop_one();
      n_cmp++;
      if (rx_valid_l !== 1'b0 || fifo_count_l !== 2'd0) begin
         n_err++;
         $display("FAIL order_pop: got valid=%b fc=%0d, need 0 0", rx_valid_l, fifo_count_l);
      end
   endtask

   task automatic test_overrun();
      send_word(8'h01);
      send_word(8'h02);
      n_cmp++;
      if (fifo_count_l !== 2'd2 || overrun_l !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_fill: got fc=%0d ovr=%b, need 2 0", fifo_count_l, overrun_l);
      end
      send_word(8'h03);
      n_cmp++;
      if (fifo_count_l !== 2'd2 || overrun_l !== 1'b1 || rx_data_l !== 8'h01) begin
         n_err++;
         $display("FAIL ovr_drop: got fc=%0d ovr=%b data=%h, need 2 1 01", fifo_count_l, overrun_l, rx_data_l);
      end
      tick();
      n_cmp++;
      if (rx_data_l !== 8'h01 || rx_valid_l !== 1'b1 || overrun_l !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_stall_hold: got data=%h valid=%b ovr=%b, need 01 1 1", rx_data_l, rx_valid_l, overrun_l);
      end
      pop_one();
      n_cmp++;
      if (rx_data_l !== 8'h02 || fifo_count_l !== 2'd1) begin
         n_err++;
         $display("FAIL ovr_pop1: got data=%h fc=%0d, need 02 1", rx_data_l, fifo_count_l);
      end
      pop_one();
      n_cmp++;
      if (rx_valid_l !== 1'b0 || fifo_count_l !== 2'd0 || overrun_l !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_pop2: got valid=%b fc=%0d ovr=%b, need 0 0 1", rx_valid_l, fifo_count_l, overrun_l);
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      n_cmp++;
      if (overrun_l !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_clear: got ovr=%b, need 0", overrun_l);
      end
   endtask

   task automatic test_clear_vs_drop();
      send_word(8'h44);
      send_word(8'h55);
      clear_err = 1'b1;
      send_word(8'h66);
      n_cmp++;
      if (overrun_l !== 1'b1 || fifo_count_l !== 2'd2) begin
         n_err++;
         $display("FAIL set_wins: got ovr=%b fc=%0d, need 1 2", overrun_l, fifo_count_l);
      end
      tick();
      clear_err = 1'b0;
      n_cmp++;
      if (overrun_l !== 1'b0) begin
         n_err++;
         $display("FAIL clear_after_drop: got ovr=%b, need 0", overrun_l);
      end
      pop_one();
      pop_one();
   endtask

   task automatic test_abort();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      abort = 1'b1;
      send_bit(1'b1);
      abort = 1'b0;
      n_cmp++;
      if (bit_cnt_l !== 4'd0 || fifo_count_l !== 2'd0) begin
         n_err++;
         $display("FAIL abort_mid: got cnt=%0d fc=%0d, need 0 0", bit_cnt_l, fifo_count_l);
      end
      send_word(8'hA5);
      n_cmp++;
      if (rx_data_l !== 8'hA5 || fifo_count_l !== 2'd1) begin
         n_err++;
         $display("FAIL abort_clean_word: got data=%h fc=%0d, need a5 1", rx_data_l, fifo_count_l);
      end
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      abort = 1'b1;
      send_bit(1'b0);
      abort = 1'b0;
      n_cmp++;
      if (bit_cnt_l !== 4'd0 || fifo_count_l !== 2'd1 || rx_data_l !== 8'hA5) begin
         n_err++;
         $display("FAIL abort_last_bit: got cnt=%0d fc=%0d data=%h, need 0 1 a5", bit_cnt_l, fifo_count_l, rx_data_l);
      end
      pop_one();
   endtask

   task automatic test_full_with_pop();
      logic [7:0] w;
      send_word(8'h11);
      send_word(8'h22);
      w = 8'h33;
      for (int i = 0; i < 7; i++) send_bit(w[i]);
      rx_ready = 1'b1;
      send_bit(w[7]);
      rx_ready = 1'b0;
      n_cmp++;
      if (fifo_count_l !== 2'd2 || overrun_l !== 1'b0 || rx_data_l !== 8'h22) begin
         n_err++;
         $display("FAIL full_pop_push: got fc=%0d ovr=%b data=%h, need 2 0 22", fifo_count_l, overrun_l, rx_data_l);
      end
      pop_one();
      n_cmp++;
      if (rx_data_l !== 8'h33 || fifo_count_l !== 2'd1) begin
         n_err++;
         $display("FAIL full_pop_next: got data=%h fc=%0d, need 33 1", rx_data_l, fifo_count_l);
      end
      pop_one();
   endtask

   task automatic test_hold();
      logic [7:0] w;
      w = 8'h96;
      for (int i = 0; i < 3; i++) send_bit(w[i]);
      repeat (5) tick();
      n_cmp++;
      if (bit_cnt_l !== 4'd3 || rx_valid_l !== 1'b0) begin
         n_err++;
         $display("FAIL hold_cnt: got cnt=%0d valid=%b, need 3 0", bit_cnt_l, rx_valid_l);
      end
      for (int i = 3; i < 8; i++) send_bit(w[i]);
      n_cmp++;
      if (rx_data_l !== 8'h96 || rx_data_m !== 8'h69) begin
         n_err++;
         $display("FAIL hold_word: got lsb=%h msb=%h, need 96 69", rx_data_l, rx_data_m);
      end
      pop_one();
   endtask

   task automatic test_async_reset();
      send_word(8'hC3);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      n_cmp++;
      if (bit_cnt_l !== 4'd4 || fifo_count_l !== 2'd1) begin
         n_err++;
         $display("FAIL pre_reset: got cnt=%0d fc=%0d, need 4 1", bit_cnt_l, fifo_count_l);
      end
      #2;
      n_rst = 1'b0;
      #1;
      n_cmp++;
      if ({rx_valid_l, rx_data_l, bit_cnt_l, fifo_count_l, overrun_l} !== 16'h0) begin
         n_err++;
         $display("FAIL async_reset: got valid=%b data=%h cnt=%0d fc=%0d ovr=%b, need all 0",
                  rx_valid_l, rx_data_l, bit_cnt_l, fifo_count_l, overrun_l);
      end
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      send_word(8'h5A);
      n_cmp++;
      if (rx_data_l !== 8'h5A || rx_valid_l !== 1'b1 || fifo_count_l !== 2'd1) begin
         n_err++;
         $display("FAIL post_reset_word: got data=%h valid=%b fc=%0d, need 5a 1 1", rx_data_l, rx_valid_l, fifo_count_l);
      end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_bit_order();
      test_overrun();
      test_clear_vs_drop();
      test_abort();
      test_full_with_pop();
      test_hold();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/flex_rx_deserializer.md
Name: flex_rx_deserializer

Overview:
Parametrised serial-to-parallel receive stage for the USB receiver datapath.
- Collects bits qualified by shift_enable into WIDTH-bit words, with selectable bit order.
- Pushes completed words into a DEPTH-entry holding FIFO drained by a valid/ready handshake.
- Supports abort of a partial word (EOP or error) and reports overrun sticky status.
- Sits between the bit-unstuffing/decode logic and the packet-level RX controller.

Parameters:
WIDTH, 8, word width in bits (2..32).
DEPTH, 2, holding FIFO entries (power of 2, 1..16).
MSB_FIRST, 0, 0 = first received bit lands in bit 0 (USB order); 1 = first received bit lands in bit WIDTH-1.

Ports:
clk  input  1  system clock, all state on rising edge.
n_rst  input  1  asynchronous active-low reset.
shift_enable  input  1  sample serial_in this cycle.
serial_in  input  1  serial data bit.
abort  input  1  sync; discard partial word, return to IDLE.
clear_err  input  1  sync; clears overrun.
rx_data  output  WIDTH  FIFO head word.
rx_valid  output  1  FIFO non-empty.
rx_ready  input  1  consumer accepts head when rx_valid & rx_ready.
bit_cnt  output  $clog2(WIDTH+1)  bits held in current partial word.
fifo_count  output  $clog2(DEPTH+1)  words stored.
overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (n_rst low, async): state IDLE, shift reg 0, bit_cnt 0, FIFO empty, rx_valid 0, rx_data 0, fifo_count 0, overrun 0.
- States: IDLE (bit_cnt==0), RECV (0<bit_cnt<WIDTH).
- IDLE -> RECV on shift_enable & !abort.
- RECV -> IDLE on the WIDTH-th shift_enable (word complete), or on abort.
- Shift, MSB_FIRST=0: sr <= {serial_in, sr[WIDTH-1:1]}.
- Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], serial_in}.
- Word complete: the assembled word, including the bit sampled this cycle, is pushed into the FIFO on the same edge; bit_cnt returns to 0.
- Latency: rx_valid rises the cycle after the edge that samples the final bit. rx_data is the registered FIFO head, valid whenever rx_valid=1.
- Pop: on rx_valid & rx_ready, head advances on the edge. rx_data/rx_valid are stable while rx_valid & !rx_ready.
- Full FIFO + word complete + no pop in the same cycle: word dropped, FIFO unchanged, overrun <= 1.
- Full FIFO + simultaneous pop: push accepted, no overrun.
- Empty FIFO + simultaneous push: rx_valid asserts the next cycle; no bypass.
- abort: clears sr and bit_cnt, state -> IDLE. abort wins over a coincident shift_enable, including the completing bit, so no push occurs. abort does not touch FIFO contents or overrun.
- clear_err: overrun <= 0. If a drop occurs in the same cycle, set wins (overrun stays 1).
- shift_enable low: sr and bit_cnt hold indefinitely.
- Pointers: wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Optional Feature:
Macro: FLEX_RX_DESER_PARITY_EN.
- Defined:
  - Each word is followed by one extra shift_enable bit, an odd parity bit; state PARITY sits between RECV and IDLE.
  - The word is pushed only if parity is correct; on mismatch the word is discarded and output parity_err (1 bit) pulses high for one cycle.
  - abort in PARITY discards the word.
- Undefined: no PARITY state, no parity_err port, word pushes on its WIDTH-th bit.

Decomposition:
- Package flex_rx_deser_pkg: state enum typedef (IDLE, RECV, PARITY), width helper functions (cnt_w(n) = $clog2(n+1)).
- Sub-module flex_rx_deser_fifo: WIDTH/DEPTH synchronous FIFO.
  - Ports: push, push_data, pop, full, empty, count.
  - Holds all pointer, count and storage logic.
- Top level: FSM, shift register and overrun logic.

Test Plan:
1. WIDTH=8, MSB_FIRST=0; shift bits 1,0,1,1,0,0,1,0 on consecutive cycles -> rx_data=8'h4D, rx_valid high the cycle after the 8th bit, bit_cnt back to 0.
2. Same bits with MSB_FIRST=1 -> rx_data=8'hB2.
3. DEPTH=2, rx_ready=0; receive 3 words 8'h01, 8'h02, 8'h03 -> fifo_count=2, overrun=1, pops yield 01 then 02. clear_err -> overrun=0.
4. After 5 bits, assert abort coincident with a shift -> bit_cnt=0, no push. The next 8 bits form a clean word.
5. FIFO full, rx_ready=1 in the cycle the 8th bit arrives -> new word accepted, overrun stays 0, fifo_count stays 2.
6. Drop n_rst mid-word (bit_cnt=4) with 1 word stored -> all outputs 0 immediately. After release, a full 8-bit word is received correctly.
